// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle controller: FSM states, ALU operation codes,
// instruction Op classes and the data-processing command lookup.
package mc_ctrl_pkg;

    localparam int STATE_W = 4;
    localparam int CNT_W   = 4;

    localparam logic [STATE_W-1:0] S_FETCH   = 4'd0;
    localparam logic [STATE_W-1:0] S_DECODE  = 4'd1;
    localparam logic [STATE_W-1:0] S_MEMADR  = 4'd2;
    localparam logic [STATE_W-1:0] S_MEMRD   = 4'd3;
    localparam logic [STATE_W-1:0] S_MEMWB   = 4'd4;
    localparam logic [STATE_W-1:0] S_MEMWR   = 4'd5;
    localparam logic [STATE_W-1:0] S_EXECR   = 4'd6;
    localparam logic [STATE_W-1:0] S_EXECI   = 4'd7;
    localparam logic [STATE_W-1:0] S_MULWAIT = 4'd8;
    localparam logic [STATE_W-1:0] S_ALUWB   = 4'd9;
    localparam logic [STATE_W-1:0] S_BRANCH  = 4'd10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_MUL = 3'b100;
    localparam logic [2:0] ALU_MOV = 3'b101;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MUL = 4'b1001;
    localparam logic [3:0] CMD_MOV = 4'b1101;

    typedef struct packed {
        logic [2:0] code;
        logic       valid;
        logic       arith;
        logic       mul;
    } alu_dec_t;

    // Funct[4:1] -> ALU code; arith marks ops whose S bit also updates C/V.
    function automatic alu_dec_t alu_lookup(input logic [3:0] cmd);
        alu_dec_t d;
        d       = '0;
        d.valid = 1'b1;
        case (cmd)
            CMD_ADD: begin d.code = ALU_ADD; d.arith = 1'b1; end
            CMD_SUB: begin d.code = ALU_SUB; d.arith = 1'b1; end
            CMD_AND: d.code = ALU_AND;
            CMD_ORR: d.code = ALU_ORR;
            CMD_MUL: begin d.code = ALU_MUL; d.mul = 1'b1; end
            CMD_MOV: d.code = ALU_MOV;
            default: d.valid = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Instruction fields in, datapath strobes and selects out, between datapath and controller.
interface mc_ctrl_if #(
    parameter int ALUCTRL_W = 3
);
    logic [1:0]           Op;
    logic [5:0]           Funct;
    logic [3:0]           Rd;
    logic [1:0]           FlagW;
    logic                 PCS;
    logic                 NextPC;
    logic                 RegW;
    logic                 MemW;
    logic                 IRWrite;
    logic                 AdrSrc;
    logic [1:0]           ResultSrc;
    logic [1:0]           ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ImmSrc;
    logic [1:0]           RegSrc;
    logic [ALUCTRL_W-1:0] ALUControl;
    logic                 Busy;

    modport master (
        output Op, Funct, Rd,
        input  FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
        input  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Busy
    );

    modport slave (
        input  Op, Funct, Rd,
        output FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc,
        output ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Busy
    );
endinterface

// File: rtl/mc_alu_dec.sv
// Combinational ALU decoder: maps Funct to ALUControl and flag-write enables.
module mc_alu_dec
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 3
) (
    input  logic                 en_i,
    input  logic                 flag_en_i,
    input  logic [5:0]           funct_i,
    output logic [ALUCTRL_W-1:0] alu_ctrl_o,
    output logic [1:0]           flag_w_o,
    output logic                 valid_o,
    output logic                 is_mul_o
);

    alu_dec_t dec;

    assign dec      = alu_lookup(funct_i[4:1]);
    assign valid_o  = dec.valid;
    assign is_mul_o = dec.mul;

    // Unsupported commands decode as a NOP: no ALU op and no flag update.
    always_comb begin
        alu_ctrl_o = '0;
        flag_w_o   = 2'b00;
        if (en_i && dec.valid) begin
            alu_ctrl_o[2:0] = dec.code;
        end
        if (flag_en_i && dec.valid) begin
            flag_w_o = {funct_i[0], funct_i[0] & dec.arith};
        end
    end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Multicycle Moore controller: FSM, MUL iteration counter and PC-write logic.
module mc_ctrl_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W  = 3,
    parameter int MUL_CYCLES = 4
) (
    input  logic     clk,
    input  logic     reset,
    mc_ctrl_if.slave bus
);

    logic [STATE_W-1:0]   state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [5:0]           funct_q, funct_d;

    logic [5:0]           dec_funct;
    logic                 alu_en, flag_en;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [1:0]           flag_w;
    logic                 dec_valid, dec_mul;

    logic                 branch, regw, memw, irwrite, nextpc, adrsrc, pcs;
    logic [1:0]           ressrc, srca, srcb, regsrc;

    // Funct is captured on leaving DECODE so later instruction-field changes
    // cannot disturb an instruction already in flight.
    assign dec_funct = (state_q == S_DECODE) ? bus.Funct : funct_q;

    mc_alu_dec #(.ALUCTRL_W(ALUCTRL_W)) u_alu_dec (
        .en_i       (alu_en),
        .flag_en_i  (flag_en),
        .funct_i    (dec_funct),
        .alu_ctrl_o (alu_ctrl),
        .flag_w_o   (flag_w),
        .valid_o    (dec_valid),
        .is_mul_o   (dec_mul)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        funct_d = funct_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                funct_d = bus.Funct;
                case (bus.Op)
                    OP_DP: begin
                        if (bus.Funct[5]) begin
                            state_d = S_EXECI;
                        end else if (dec_mul) begin
                            state_d = S_MULWAIT;
                            cnt_d   = CNT_W'(MUL_CYCLES - 1);
                        end else begin
                            state_d = S_EXECR;
                        end
                    end
                    OP_MEM:  state_d = S_MEMADR;
                    OP_BR:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = funct_q[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_d = S_MEMWB;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = S_FETCH;
            S_EXECR:   state_d = S_ALUWB;
            S_EXECI:   state_d = S_ALUWB;
            S_MULWAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_ALUWB;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_ALUWB:   state_d = S_FETCH;
            S_BRANCH:  state_d = S_FETCH;
            default:   state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            funct_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            funct_q <= funct_d;
        end
    end

    always_comb begin
        branch  = 1'b0;
        regw    = 1'b0;
        memw    = 1'b0;
        irwrite = 1'b0;
        nextpc  = 1'b0;
        adrsrc  = 1'b0;
        ressrc  = 2'b00;
        srca    = 2'b00;
        srcb    = 2'b00;
        alu_en  = 1'b0;
        flag_en = 1'b0;
        case (state_q)
            S_FETCH: begin
                irwrite = 1'b1;
                nextpc  = 1'b1;
                srca    = 2'b10;
                srcb    = 2'b10;
                ressrc  = 2'b10;
            end
            S_DECODE: begin
                srca   = 2'b10;
                srcb   = 2'b10;
                ressrc = 2'b10;
            end
            S_MEMADR: srcb = 2'b01;
            S_MEMRD:  adrsrc = 1'b1;
            S_MEMWB: begin
                ressrc = 2'b01;
                regw   = 1'b1;
            end
            S_MEMWR: begin
                adrsrc = 1'b1;
                memw   = 1'b1;
            end
            S_EXECR: begin
                alu_en  = 1'b1;
                flag_en = 1'b1;
            end
            S_EXECI: begin
                srcb    = 2'b01;
                alu_en  = 1'b1;
                flag_en = 1'b1;
            end
            // Flags are written only once the multiply result is final.
            S_MULWAIT: begin
                alu_en  = 1'b1;
                flag_en = (cnt_q == '0);
            end
            S_ALUWB:  regw = dec_valid;
            S_BRANCH: begin
                srcb   = 2'b01;
                ressrc = 2'b10;
                branch = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        case (bus.Op)
            OP_MEM:  regsrc = {~bus.Funct[0], 1'b0};
            OP_BR:   regsrc = 2'b01;
            default: regsrc = 2'b00;
        endcase
    end

    assign pcs = branch | (regw & (bus.Rd == 4'hF));

    // Reset masks every output so an abandoned instruction cannot write anything.
    assign bus.FlagW      = reset ? 2'b00 : flag_w;
    assign bus.PCS        = ~reset & pcs;
    assign bus.NextPC     = ~reset & nextpc;
    assign bus.RegW       = ~reset & regw;
    assign bus.MemW       = ~reset & memw;
    assign bus.IRWrite    = ~reset & irwrite;
    assign bus.AdrSrc     = ~reset & adrsrc;
    assign bus.ResultSrc  = reset ? 2'b00 : ressrc;
    assign bus.ALUSrcA    = reset ? 2'b00 : srca;
    assign bus.ALUSrcB    = reset ? 2'b00 : srcb;
    assign bus.ImmSrc     = reset ? 2'b00 : bus.Op;
    assign bus.RegSrc     = reset ? 2'b00 : regsrc;
    assign bus.ALUControl = reset ? '0 : alu_ctrl;
    assign bus.Busy       = ~reset & (state_q == S_MULWAIT);

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Directed checks of mc_ctrl_unit with MUL_CYCLES=4 and MUL_CYCLES=1 instances.
module tb_mc_ctrl_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] op = 2'b00;
    logic [5:0] funct = 6'd0;
    logic [3:0] rd = 4'd0;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    mc_ctrl_if #(.ALUCTRL_W(3)) b4 ();
    mc_ctrl_if #(.ALUCTRL_W(3)) b1 ();

    assign b4.Op = op;
    assign b4.Funct = funct;
    assign b4.Rd = rd;
    assign b1.Op = op;
    assign b1.Funct = funct;
    assign b1.Rd = rd;

    mc_ctrl_unit #(.ALUCTRL_W(3), .MUL_CYCLES(4)) dut4 (.clk(clk), .reset(reset), .bus(b4));
    mc_ctrl_unit #(.ALUCTRL_W(3), .MUL_CYCLES(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

    // {FlagW, PCS, NextPC, RegW, MemW, IRWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc, RegSrc, ALUControl, Busy}
    logic [21:0] o4, o1;
    assign o4 = {b4.FlagW, b4.PCS, b4.NextPC, b4.RegW, b4.MemW, b4.IRWrite, b4.AdrSrc,
                 b4.ResultSrc, b4.ALUSrcA, b4.ALUSrcB, b4.ImmSrc, b4.RegSrc, b4.ALUControl, b4.Busy};
    assign o1 = {b1.FlagW, b1.PCS, b1.NextPC, b1.RegW, b1.MemW, b1.IRWrite, b1.AdrSrc,
                 b1.ResultSrc, b1.ALUSrcA, b1.ALUSrcB, b1.ImmSrc, b1.RegSrc, b1.ALUControl, b1.Busy};

    function automatic logic [21:0] ov(input logic [1:0] fw, input logic pcs, input logic npc,
                                       input logic rw, input logic mw, input logic irw, input logic adr,
                                       input logic [1:0] res, input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] imm, input logic [1:0] rs,
                                       input logic [2:0] alu, input logic busy);
        return {fw, pcs, npc, rw, mw, irw, adr, res, sa, sb, imm, rs, alu, busy};
    endfunction

    function automatic logic [21:0] v_fetch(input logic [1:0] imm, input logic [1:0] rs);
        return ov(2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b10, 2'b10, 2'b10, imm, rs, 3'b000, 1'b0);
    endfunction

    function automatic logic [21:0] v_decode(input logic [1:0] imm, input logic [1:0] rs);
        return ov(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b10, imm, rs, 3'b000, 1'b0);
    endfunction

    task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("reset_zero4", o4, 22'd0);
        chk("reset_zero1", o1, 22'd0);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "timeout");
    end

    logic [5:0] tf  [4];
    logic [2:0] ta  [4];
    logic [1:0] tfw [4];

    initial begin
        tick();
        // ADD S=1, register operand
        op = 2'b00; funct = 6'b001001; rd = 4'd2;
        do_reset();
        chk("add_fetch", o4, v_fetch(2'b00, 2'b00));
        tick(); chk("add_decode", o4, v_decode(2'b00, 2'b00));
        tick(); chk("add_execr", o4, ov(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        tick(); chk("add_aluwb", o4, ov(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
        tick(); chk("add_refetch", o4, v_fetch(2'b00, 2'b00));

        // MUL: 4 busy cycles on dut4, 1 on dut1
        op = 2'b00; funct = 6'b010010; rd = 4'd3;
        do_reset();
        chk("mul_fetch4", o4, v_fetch(2'b00, 2'b00));
        chk("mul_fetch1", o1, v_fetch(2'b00, 2'b00));
        tick(); chk("mul_decode4", o4, v_decode(2'b00, 2'b00));
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mul4_wait", o4, ov(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100, 1'b1));
            case (i)
                0: chk("mul1_wait", o1, ov(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b100, 1'b1));
                1: chk("mul1_aluwb", o1, ov(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
                2: chk("mul1_fetch", o1, v_fetch(2'b00, 2'b00));
                default: chk("mul1_decode", o1, v_decode(2'b00, 2'b00));
            endcase
        end
        tick(); chk("mul4_aluwb", o4, ov(2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));

        // Reset in the 2nd MULWAIT cycle
        do_reset();
        tick(); tick(); tick();
        reset = 1'b1;
        #1; chk("rst_mid_zero", o4, 22'd0);
        tick();
        reset = 1'b0;
        #1; chk("rst_mid_fetch", o4, v_fetch(2'b00, 2'b00));
        tick(); chk("rst_mid_decode", o4, v_decode(2'b00, 2'b00));

        // LDR to R15
        op = 2'b01; funct = 6'b011001; rd = 4'hF;
        do_reset();
        chk("ldr_fetch", o4, v_fetch(2'b01, 2'b00));
        tick(); chk("ldr_decode", o4, v_decode(2'b01, 2'b00));
        tick(); chk("ldr_memadr", o4, ov(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0));
        tick(); chk("ldr_memrd", o4, ov(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0));
        tick(); chk("ldr_memwb", o4, ov(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 3'b000, 1'b0));
        tick(); chk("ldr_refetch", o4, v_fetch(2'b01, 2'b00));

        // STR
        op = 2'b01; funct = 6'b011000; rd = 4'd4;
        do_reset();
        chk("str_fetch", o4, v_fetch(2'b01, 2'b10));
        tick(); chk("str_decode", o4, v_decode(2'b01, 2'b10));
        tick(); chk("str_memadr", o4, ov(2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000, 1'b0));
        tick(); chk("str_memwr", o4, ov(2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0));
        tick(); chk("str_refetch", o4, v_fetch(2'b01, 2'b10));

        // Branch
        op = 2'b10; funct = 6'd0; rd = 4'd0;
        do_reset();
        tick(); chk("b_decode", o4, v_decode(2'b10, 2'b01));
        tick(); chk("b_branch", o4, ov(2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b01, 2'b10, 2'b01, 3'b000, 1'b0));
        tick(); chk("b_refetch", o4, v_fetch(2'b10, 2'b01));

        // SUB S=1 immediate to R15
        op = 2'b00; funct = 6'b100101; rd = 4'hF;
        do_reset();
        tick(); tick();
        chk("subi_execi", o4, ov(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 3'b001, 1'b0));
        tick(); chk("subi_aluwb", o4, ov(2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));

        // Unsupported command behaves as NOP
        op = 2'b00; funct = 6'b001111; rd = 4'd5;
        do_reset();
        tick(); tick();
        chk("nop_execr", o4, 22'd0);
        tick(); chk("nop_aluwb", o4, 22'd0);
        tick(); chk("nop_refetch", o4, v_fetch(2'b00, 2'b00));

        // Op=11 returns to FETCH without writes
        op = 2'b11; funct = 6'd0; rd = 4'd0;
        do_reset();
        tick(); chk("op11_decode", o4, v_decode(2'b11, 2'b00));
        tick(); chk("op11_fetch", o4, v_fetch(2'b11, 2'b00));

        // Remaining ALU codes via EXECR
        tf[0] = 6'b011001; ta[0] = 3'b011; tfw[0] = 2'b10;
        tf[1] = 6'b000001; ta[1] = 3'b010; tfw[1] = 2'b10;
        tf[2] = 6'b011010; ta[2] = 3'b101; tfw[2] = 2'b00;
        tf[3] = 6'b001000; ta[3] = 3'b000; tfw[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            op = 2'b00; funct = tf[k]; rd = 4'd1;
            do_reset();
            tick(); tick();
            chk("alu_table", o4, ov(tfw[k], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, ta[k], 1'b0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_unit.md
MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 SHALL have parameter ALUCTRL_W, default 3, ALUControl width; legal values are at least 3.
REQ-002 SHALL have parameter MUL_CYCLES, default 4, total execute cycles of a MUL; legal range 1..16.
REQ-003 SHALL have port clk, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous and active-high.
REQ-005 SHALL have port Op, input, 2, Instr[27:26].
REQ-006 SHALL have port Funct, input, 6, Instr[25:20].
REQ-007 SHALL have port Rd, input, 4, Instr[15:12].
REQ-008 SHALL have port FlagW, output, 2: [1] updates NZ, [0] updates CV.
REQ-009 SHALL have ports PCS, NextPC, RegW, MemW, IRWrite and AdrSrc, each an output of width 1, as datapath and condlogic strobes.
REQ-010 SHALL have ports ResultSrc, ALUSrcA, ALUSrcB, ImmSrc and RegSrc, each an output of width 2, as datapath mux selects.
REQ-011 SHALL have port ALUControl, output, ALUCTRL_W, the ALU operation.
REQ-012 SHALL have port Busy, output, 1, high while a MUL is iterating.

Function
REQ-013 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, MULWAIT, ALUWB and BRANCH.
REQ-014 SHALL use these transitions:
- FETCH to DECODE.
- DECODE, Op=00: Funct[5]=1 goes to EXECI; MUL goes to MULWAIT; otherwise EXECR.
- DECODE, Op=01 goes to MEMADR; Op=10 goes to BRANCH; Op=11 goes to FETCH.
- MEMADR: Funct[0]=1 goes to MEMRD, otherwise MEMWR.
- MEMRD to MEMWB to FETCH.
- MEMWR to FETCH.
- EXECR and EXECI to ALUWB to FETCH.
- BRANCH to FETCH.
REQ-015 SHALL drive outputs as zero except as listed:
- FETCH: IRWrite=1, NextPC=1, ALUSrcA=10, ALUSrcB=10, ResultSrc=10.
- DECODE: ALUSrcA=10, ALUSrcB=10, ResultSrc=10.
- MEMADR: ALUSrcB=01.
- MEMRD: AdrSrc=1.
- MEMWB: ResultSrc=01, RegW=1.
- MEMWR: AdrSrc=1, MemW=1.
- EXECR and MULWAIT: ALUSrcB=00, with the ALU decoder enabled.
- EXECI: ALUSrcB=01, with the ALU decoder enabled.
- ALUWB: RegW=1.
- BRANCH: ALUSrcB=01, ResultSrc=10, with internal Branch=1.
REQ-016 SHALL, when the ALU decoder is enabled, decode Funct[4:1] as follows:
- 0100 (ADD) gives 000; 0010 (SUB) gives 001; 0000 (AND) gives 010.
- 1100 (ORR) gives 011; 1001 (MUL) gives 100; 1101 (MOV) gives 101.
- The result is zero-extended to ALUCTRL_W.
REQ-017 SHALL drive ALUControl=0 when the ALU decoder is disabled (address, PC and branch adds).
REQ-018 SHALL treat an unsupported Funct[4:1] as a NOP: ALUControl=0, FlagW=00, and RegW suppressed in ALUWB.
REQ-019 SHALL drive FlagW[1]=Funct[0] and FlagW[0]=Funct[0]&(ADD|SUB), asserted only in EXECR, EXECI and the final MULWAIT cycle.
REQ-020 SHALL, on entering MULWAIT, load a counter with MUL_CYCLES-1 and decrement it each cycle.
REQ-021 SHALL leave MULWAIT for ALUWB when the counter is 0; MUL_CYCLES=1 gives exactly one MULWAIT cycle.
REQ-022 SHALL hold Busy=1 for exactly the MULWAIT cycles.
REQ-023 SHALL hold ALUControl and the selects constant throughout MULWAIT.
REQ-024 SHALL drive PCS=Branch|(RegW&(Rd==4'hF)), combinational from the current state.
REQ-025 SHALL decode ImmSrc=Op.
REQ-026 SHALL decode RegSrc as 00 for Op=00, 10 for LDR/STR with STR setting RegSrc[1], and 01 for Op=10.
REQ-027 SHALL make Op, Funct and Rd changes outside DECODE, MEMADR and execute states affect no state transition.

Reset
REQ-028 SHALL, when reset is high at a rising edge, load state FETCH and clear the MUL counter.
REQ-029 SHALL force all outputs to 0 while reset is high.
REQ-030 SHALL, when reset is asserted mid-instruction (including MULWAIT), abandon the instruction with no RegW or MemW pulse in the following cycles.
REQ-031 SHALL enter FETCH, with IRWrite=1, in the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the state encoding, the ALUControl codes (ALU_ADD..ALU_MOV) and the Op codes in shared package mc_ctrl_pkg.
REQ-033 SHALL isolate the ALU decoder (REQ-016..REQ-019) as combinational sub-module mc_alu_dec.
REQ-034 SHALL keep the FSM, the MUL counter and the PC logic in mc_ctrl_unit.

Verification
REQ-035 SHALL verify ADD with S=1: Op=00, Funct=001001, Rd=2 produces FETCH, DECODE, EXECR, ALUWB; ALUControl=000 and FlagW=11 in EXECR; RegW=1 and PCS=0 in ALUWB.
REQ-036 SHALL verify MUL with MUL_CYCLES=4: Funct=010010 produces Busy=1 for 4 cycles with ALUControl=100, then ALUWB; with MUL_CYCLES=1, Busy=1 for 1 cycle.
REQ-037 SHALL verify LDR: Op=01, Funct=011001 produces MEMADR, MEMRD (AdrSrc=1), MEMWB (ResultSrc=01, RegW=1); with Rd=15, PCS=1 in MEMWB.
REQ-038 SHALL verify STR and B:
- STR (Funct[0]=0) produces MemW=1 for exactly one cycle.
- B (Op=10) produces PCS=1 in BRANCH, then FETCH.
REQ-039 SHALL verify reset mid-operation: reset asserted in the 2nd MULWAIT cycle gives all outputs 0 that cycle, FETCH next, and no RegW pulse.
REQ-040 SHALL verify unsupported cases:
- Funct[4:1]=0111 produces ALUControl=000, FlagW=00 and RegW=0 in ALUWB.
- Op=11 goes to FETCH with no writes.
